lock_access_ctrl: RTL and testbench

- Access sequencer placed after the keypad code checker. It turns the checker's door_status_correct / door_status_incorrect results into door-actuator commands.
- Enforces a timed unlock window, counts consecutive failed attempts, imposes a timed lockout after too many failures, and raises a door-forced alarm.
- Gates keypad entry and issues a keypad clear pulse after every attempt, so the checker restarts from a clean state.

---
 rtl/lock_access_if.sv | 23 ++
 rtl/lock_access_ctrl.sv | 135 +++++++++++++
 tb/tb_lock_access_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/lock_access_if.sv
// Signal bundle between the keypad checker / door sensor side and the access sequencer.
// The master drives the checker results and the door sensor; the slave drives the door commands.
interface lock_access_if;
    logic       door_status_correct;
    logic       door_status_incorrect;
    logic       door_open;
    logic       keypad_enable;
    logic       keypad_clear;
    logic       unlock;
    logic       lockout;
    logic       alarm;
    logic [2:0] fail_count;

    modport master (
        output door_status_correct, door_status_incorrect, door_open,
        input  keypad_enable, keypad_clear, unlock, lockout, alarm, fail_count
    );

    modport slave (
        input  door_status_correct, door_status_incorrect, door_open,
        output keypad_enable, keypad_clear, unlock, lockout, alarm, fail_count
    );
endinterface

// File: rtl/lock_access_ctrl.sv
// Door access sequencer: timed unlock window, failed-attempt counting with timed lockout,
// sticky door-forced alarm, and keypad gating/clear after every attempt.
module lock_access_ctrl #(
    parameter int UNLOCK_CYCLES  = 50,
    parameter int LOCKOUT_CYCLES = 200,
    parameter int MAX_FAILS      = 3
) (
    input  logic          clk,
    input  logic          reset,
    lock_access_if.slave  bus
);

    localparam int MAX_CYCLES = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TW         = $clog2(MAX_CYCLES + 1);

    localparam logic [TW-1:0] UNLOCK_LOAD  = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0]    FAIL_LIMIT   = 3'(MAX_FAILS);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] UNLOCKED = 3'd1;
    localparam logic [2:0] RELOCK   = 3'd2;
    localparam logic [2:0] FAIL     = 3'd3;
    localparam logic [2:0] LOCKOUT  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    fail_count_q, fail_count_d;
    logic          alarm_q, alarm_d;
    logic          unlock_q, unlock_d;
    logic          lockout_q, lockout_d;
    logic          keypad_clear_q, keypad_clear_d;
    logic          correct_q, incorrect_q;
    logic          ok_e, bad_e, alarm_clr;

    always_comb begin
        ok_e         = bus.door_status_correct & ~correct_q;
        bad_e        = bus.door_status_incorrect & ~incorrect_q;
        state_d      = state_q;
        timer_d      = timer_q;
        fail_count_d = fail_count_q;
        alarm_clr    = 1'b0;

        case (state_q)
            IDLE: begin
                // A simultaneous good and bad result is treated as a failure.
                if (bad_e) begin
                    state_d = FAIL;
                    if (fail_count_q != 3'd7) begin
                        fail_count_d = fail_count_q + 3'd1;
                    end
                end else if (ok_e) begin
                    state_d      = UNLOCKED;
                    timer_d      = UNLOCK_LOAD;
                    fail_count_d = 3'd0;
                    alarm_clr    = 1'b1;
                end
            end
            UNLOCKED: begin
                // Once the window expires, hold the lock open until the door is shut.
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else if (!bus.door_open) begin
                    state_d = RELOCK;
                end
            end
            RELOCK: begin
                state_d = IDLE;
            end
            FAIL: begin
                if (fail_count_q >= FAIL_LIMIT) begin
                    state_d = LOCKOUT;
                    timer_d = LOCKOUT_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOCKOUT: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else begin
                    state_d      = IDLE;
                    fail_count_d = 3'd0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        alarm_d = alarm_q;
        if (alarm_clr) begin
            alarm_d = 1'b0;
        end else if (bus.door_open && (state_q != UNLOCKED)) begin
            alarm_d = 1'b1;
        end

        // Command outputs are registered copies of the next-state decode.
        unlock_d       = (state_d == UNLOCKED);
        lockout_d      = (state_d == LOCKOUT);
        keypad_clear_d = (state_d == RELOCK) || (state_d == FAIL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            timer_q        <= '0;
            fail_count_q   <= 3'd0;
            alarm_q        <= 1'b0;
            unlock_q       <= 1'b0;
            lockout_q      <= 1'b0;
            keypad_clear_q <= 1'b0;
            correct_q      <= 1'b0;
            incorrect_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            fail_count_q   <= fail_count_d;
            alarm_q        <= alarm_d;
            unlock_q       <= unlock_d;
            lockout_q      <= lockout_d;
            keypad_clear_q <= keypad_clear_d;
            correct_q      <= bus.door_status_correct;
            incorrect_q    <= bus.door_status_incorrect;
        end
    end

    assign bus.keypad_enable = (state_q == IDLE);
    assign bus.keypad_clear  = keypad_clear_q;
    assign bus.unlock        = unlock_q;
    assign bus.lockout       = lockout_q;
    assign bus.alarm         = alarm_q;
    assign bus.fail_count    = fail_count_q;

endmodule

// File: tb/tb_lock_access_ctrl.sv
// Scoreboard bench for lock_access_ctrl: stimulus pushes hand-computed output vectors,
// a monitor pops one after every clock edge and compares.
`timescale 1ns/100ps
module tb_lock_access_ctrl;

    logic clk;
    logic reset;

    lock_access_if bus();

    lock_access_ctrl #(
        .UNLOCK_CYCLES (4),
        .LOCKOUT_CYCLES(8),
        .MAX_FAILS     (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector layout: {keypad_enable, keypad_clear, unlock, lockout, alarm, fail_count[2:0]}
    logic [7:0] exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc_no = 0;
    logic [7:0] mon_exp;
    logic [7:0] mon_got;

    function automatic logic [7:0] ev(input int ke, input int kc, input int ul,
                                      input int lo, input int al, input int fc);
        return {ke[0], kc[0], ul[0], lo[0], al[0], fc[2:0]};
    endfunction

    function automatic logic [7:0] outs();
        return {bus.keypad_enable, bus.keypad_clear, bus.unlock, bus.lockout,
                bus.alarm, bus.fail_count};
    endfunction

    // Drive inputs on the falling edge; the expected vector is what the
    // outputs must show just after the following rising edge.
    task automatic cyc(input int c, input int i, input int d, input logic [7:0] e);
        @(negedge clk);
        bus.door_status_correct   = c[0];
        bus.door_status_incorrect = i[0];
        bus.door_open             = d[0];
        exp_q.push_back(e);
    endtask

    task automatic chk_now(input string name, input logic [7:0] e);
        logic [7:0] g;
        g = outs();
        n_cmp++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL %s: got ke,kc,ul,lo,al,fc=%b required=%b", name, g, e);
        end else begin
            $display("check %s ok: %b", name, g);
        end
    endtask

    // Monitor: one comparison per clock edge that has a pending expectation.
    always begin
        @(posedge clk);
        #1;
        cyc_no++;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_got = outs();
            n_cmp++;
            if (mon_got !== mon_exp) begin
                n_bad++;
                $display("FAIL cycle %0d: got ke,kc,ul,lo,al,fc=%b required=%b",
                         cyc_no, mon_got, mon_exp);
            end else begin
                $display("cycle %0d ok: %b", cyc_no, mon_got);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset                     = 1'b1;
        bus.door_status_correct   = 1'b0;
        bus.door_status_incorrect = 1'b0;
        bus.door_open             = 1'b0;
        #1;
        chk_now("reset_state", ev(1, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        $display("-- correct entry, door closed");
        cyc(1, 0, 0, ev(0, 0, 1, 0, 0, 0));
        repeat (3) cyc(0, 0, 0, ev(0, 0, 1, 0, 0, 0));
        cyc(0, 0, 0, ev(0, 1, 0, 0, 0, 0));
        repeat (2) cyc(0, 0, 0, ev(1, 0, 0, 0, 0, 0));

        $display("-- correct held for 20 cycles");
        repeat (4) cyc(1, 0, 0, ev(0, 0, 1, 0, 0, 0));
        cyc(1, 0, 0, ev(0, 1, 0, 0, 0, 0));
        repeat (15) cyc(1, 0, 0, ev(1, 0, 0, 0, 0, 0));
        repeat (2) cyc(0, 0, 0, ev(1, 0, 0, 0, 0, 0));

        $display("-- three failures then lockout");
        cyc(0, 1, 0, ev(0, 1, 0, 0, 0, 1));
        cyc(0, 0, 0, ev(1, 0, 0, 0, 0, 1));
        cyc(0, 1, 0, ev(0, 1, 0, 0, 0, 2));
        cyc(0, 0, 0, ev(1, 0, 0, 0, 0, 2));
        cyc(0, 1, 0, ev(0, 1, 0, 0, 0, 3));
        for (int k = 0; k < 8; k++) begin
            cyc((k == 2 || k == 5) ? 1 : 0, 0, 0, ev(0, 0, 0, 1, 0, 3));
        end
        repeat (2) cyc(0, 0, 0, ev(1, 0, 0, 0, 0, 0));

        $display("-- simultaneous correct and incorrect");
        cyc(1, 1, 0, ev(0, 1, 0, 0, 0, 1));
        cyc(0, 0, 0, ev(1, 0, 0, 0, 0, 1));
        cyc(0, 0, 0, ev(1, 0, 0, 0, 0, 1));

        $display("-- door held open past unlock window");
        cyc(1, 0, 0, ev(0, 0, 1, 0, 0, 0));
        repeat (5) cyc(0, 0, 1, ev(0, 0, 1, 0, 0, 0));
        cyc(0, 0, 0, ev(0, 1, 0, 0, 0, 0));
        cyc(0, 0, 0, ev(1, 0, 0, 0, 0, 0));

        $display("-- door forced in idle, cleared by correct entry");
        cyc(0, 0, 1, ev(1, 0, 0, 0, 1, 0));
        repeat (3) cyc(0, 0, 0, ev(1, 0, 0, 0, 1, 0));
        cyc(1, 0, 0, ev(0, 0, 1, 0, 0, 0));
        repeat (3) cyc(0, 0, 0, ev(0, 0, 1, 0, 0, 0));
        cyc(0, 0, 0, ev(0, 1, 0, 0, 0, 0));
        cyc(0, 0, 0, ev(1, 0, 0, 0, 0, 0));

        $display("-- clear beats set when correct arrives with door open");
        cyc(0, 0, 1, ev(1, 0, 0, 0, 1, 0));
        cyc(1, 0, 1, ev(0, 0, 1, 0, 0, 0));
        repeat (3) cyc(0, 0, 0, ev(0, 0, 1, 0, 0, 0));
        cyc(0, 0, 0, ev(0, 1, 0, 0, 0, 0));
        cyc(0, 0, 0, ev(1, 0, 0, 0, 0, 0));

        $display("-- alarm during lockout, then async reset");
        cyc(0, 1, 0, ev(0, 1, 0, 0, 0, 1));
        cyc(0, 0, 0, ev(1, 0, 0, 0, 0, 1));
        cyc(0, 1, 0, ev(0, 1, 0, 0, 0, 2));
        cyc(0, 0, 0, ev(1, 0, 0, 0, 0, 2));
        cyc(0, 1, 0, ev(0, 1, 0, 0, 0, 3));
        cyc(0, 0, 0, ev(0, 0, 0, 1, 0, 3));
        cyc(0, 0, 1, ev(0, 0, 0, 1, 1, 3));
        cyc(0, 0, 0, ev(0, 0, 0, 1, 1, 3));
        @(posedge clk);
        #1.5;
        reset = 1'b1;
        #2;
        chk_now("async_reset_mid_lockout", ev(1, 0, 0, 0, 0, 0));
        #1;
        reset = 1'b0;
        repeat (2) cyc(0, 0, 0, ev(1, 0, 0, 0, 0, 0));

        $display("-- correct entry after reset");
        cyc(1, 0, 0, ev(0, 0, 1, 0, 0, 0));
        repeat (3) cyc(0, 0, 0, ev(0, 0, 1, 0, 0, 0));
        cyc(0, 0, 0, ev(0, 1, 0, 0, 0, 0));
        cyc(0, 0, 0, ev(1, 0, 0, 0, 0, 0));

        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
